// File: rtl/cordic_share_ctrl.sv
// cordic_share_ctrl: time-multiplexes one shared CORDIC core between the two
// operands of a stage_1 result. Captures a pair, issues operand one then two
// via start/done, and presents both results with the matching half/square
// values as one result set.
module cordic_share_ctrl #(
  parameter int unsigned FLT_DATA_WIDTH    = 32,
  parameter int unsigned CORDIC_DATA_WIDTH = 22
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         in_valid,
  input  logic [CORDIC_DATA_WIDTH-1:0] in_one,
  input  logic [CORDIC_DATA_WIDTH-1:0] in_two,
  input  logic [FLT_DATA_WIDTH-1:0]    half_in_one,
  input  logic [FLT_DATA_WIDTH-1:0]    half_in_two,
  input  logic [FLT_DATA_WIDTH-1:0]    square_in_one,
  input  logic [FLT_DATA_WIDTH-1:0]    square_in_two,
  output logic                         cordic_start,
  output logic [CORDIC_DATA_WIDTH-1:0] cordic_x,
  input  logic                         cordic_done,
  input  logic [FLT_DATA_WIDTH-1:0]    cordic_result,
  output logic                         done,
  output logic [FLT_DATA_WIDTH-1:0]    res_one,
  output logic [FLT_DATA_WIDTH-1:0]    res_two,
  output logic [FLT_DATA_WIDTH-1:0]    half_out_one,
  output logic [FLT_DATA_WIDTH-1:0]    half_out_two,
  output logic [FLT_DATA_WIDTH-1:0]    square_out_one,
  output logic [FLT_DATA_WIDTH-1:0]    square_out_two,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned FW = FLT_DATA_WIDTH;
  localparam int unsigned CW = CORDIC_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE_ONE = 3'd1,
    S_WAIT_ONE  = 3'd2,
    S_ISSUE_TWO = 3'd3,
    S_WAIT_TWO  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   op_two_q, op_two_d;
  logic [FW-1:0]   half_one_q, half_one_d;
  logic [FW-1:0]   half_two_q, half_two_d;
  logic [FW-1:0]   square_one_q, square_one_d;
  logic [FW-1:0]   square_two_q, square_two_d;
  logic [CW-1:0]   cordic_x_q, cordic_x_d;
  logic [FW-1:0]   res_one_q, res_one_d;
  logic [FW-1:0]   res_two_q, res_two_d;
  logic [FW-1:0]   half_out_one_q, half_out_one_d;
  logic [FW-1:0]   half_out_two_q, half_out_two_d;
  logic [FW-1:0]   square_out_one_q, square_out_one_d;
  logic [FW-1:0]   square_out_two_q, square_out_two_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;

  // Next-state and register-load logic; the enable gating lives in the flops
  always_comb begin
    state_d          = state_q;
    op_two_d         = op_two_q;
    half_one_d       = half_one_q;
    half_two_d       = half_two_q;
    square_one_d     = square_one_q;
    square_two_d     = square_two_q;
    cordic_x_d       = cordic_x_q;
    res_one_d        = res_one_q;
    res_two_d        = res_two_q;
    half_out_one_d   = half_out_one_q;
    half_out_two_d   = half_out_two_q;
    square_out_one_d = square_out_one_q;
    square_out_two_d = square_out_two_q;
    overrun_d        = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // operand one goes straight into the issue register
          cordic_x_d   = in_one;
          op_two_d     = in_two;
          half_one_d   = half_in_one;
          half_two_d   = half_in_two;
          square_one_d = square_in_one;
          square_two_d = square_in_two;
          state_d      = S_ISSUE_ONE;
        end
      end
      S_ISSUE_ONE: state_d = S_WAIT_ONE;
      S_WAIT_ONE: begin
        if (cordic_done) begin
          res_one_d  = cordic_result;
          cordic_x_d = op_two_q;
          state_d    = S_ISSUE_TWO;
        end
      end
      S_ISSUE_TWO: state_d = S_WAIT_TWO;
      S_WAIT_TWO: begin
        if (cordic_done) begin
          // pass-through values update together with res_two
          res_two_d        = cordic_result;
          half_out_one_d   = half_one_q;
          half_out_two_d   = half_two_q;
          square_out_one_d = square_one_q;
          square_out_two_d = square_two_q;
          state_d          = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // any pair offered while not idle is dropped and flagged
    if (in_valid && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and data registers, advancing only on enabled edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      op_two_q         <= '0;
      half_one_q       <= '0;
      half_two_q       <= '0;
      square_one_q     <= '0;
      square_two_q     <= '0;
      cordic_x_q       <= '0;
      res_one_q        <= '0;
      res_two_q        <= '0;
      half_out_one_q   <= '0;
      half_out_two_q   <= '0;
      square_out_one_q <= '0;
      square_out_two_q <= '0;
      busy_q           <= 1'b0;
      overrun_q        <= 1'b0;
    end else if (clk_en) begin
      state_q          <= state_d;
      op_two_q         <= op_two_d;
      half_one_q       <= half_one_d;
      half_two_q       <= half_two_d;
      square_one_q     <= square_one_d;
      square_two_q     <= square_two_d;
      cordic_x_q       <= cordic_x_d;
      res_one_q        <= res_one_d;
      res_two_q        <= res_two_d;
      half_out_one_q   <= half_out_one_d;
      half_out_two_q   <= half_out_two_d;
      square_out_one_q <= square_out_one_d;
      square_out_two_q <= square_out_two_d;
      busy_q           <= busy_d;
      overrun_q        <= overrun_d;
    end
  end

  // Strobes are decoded from state so each lasts exactly one enabled cycle
  assign cordic_start = clk_en && ((state_q == S_ISSUE_ONE) || (state_q == S_ISSUE_TWO));
  assign done         = clk_en && (state_q == S_DONE);

  assign cordic_x       = cordic_x_q;
  assign res_one        = res_one_q;
  assign res_two        = res_two_q;
  assign half_out_one   = half_out_one_q;
  assign half_out_two   = half_out_two_q;
  assign square_out_one = square_out_one_q;
  assign square_out_two = square_out_two_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Scoreboard bench for cordic_share_ctrl: a latency-L CORDIC stub, a
// cycle-index reference model (counting enabled cycles only) and monitors
// that pop expected start/result entries when the DUT presents them.
module tb_cordic_share_ctrl;

  localparam int unsigned FW = 32;
  localparam int unsigned CW = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_one = '0, in_two = '0;
  logic [FW-1:0] half_in_one = '0, half_in_two = '0;
  logic [FW-1:0] square_in_one = '0, square_in_two = '0;
  logic          cordic_start;
  logic [CW-1:0] cordic_x;
  logic          cordic_done = 1'b0;
  logic [FW-1:0] cordic_result = '0;
  logic          done;
  logic [FW-1:0] res_one, res_two, half_out_one, half_out_two;
  logic [FW-1:0] square_out_one, square_out_two;
  logic          busy, overrun;

  cordic_share_ctrl #(.FLT_DATA_WIDTH(FW), .CORDIC_DATA_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid),
    .in_one(in_one), .in_two(in_two),
    .half_in_one(half_in_one), .half_in_two(half_in_two),
    .square_in_one(square_in_one), .square_in_two(square_in_two),
    .cordic_start(cordic_start), .cordic_x(cordic_x),
    .cordic_done(cordic_done), .cordic_result(cordic_result),
    .done(done), .res_one(res_one), .res_two(res_two),
    .half_out_one(half_out_one), .half_out_two(half_out_two),
    .square_out_one(square_out_one), .square_out_two(square_out_two),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [CW-1:0] x; } start_t;
  typedef struct {
    int cyc;
    logic [FW-1:0] r1, r2, h1, h2, s1, s2;
  } res_t;

  start_t start_q[$];
  res_t   res_q[$];

  int checks = 0;
  int failures = 0;

  // model state, all in enabled-cycle indices
  int ec = 0;
  int acc = -100;
  int free_at = 0;
  int lat = 3;
  int ovr_from = 32'h3fff_ffff;
  int target = -1;
  logic [CW-1:0] stub_x = '0;

  function automatic logic [FW-1:0] stub_f(input logic [CW-1:0] x);
    return {{(FW-CW){1'b0}}, x} ^ FW'(32'hA5A5_0000);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_start"}, 64'(cordic_start), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    chk({tag, "_cordic_x"}, 64'(cordic_x), 64'd0);
    chk({tag, "_res_one"}, 64'(res_one), 64'd0);
    chk({tag, "_res_two"}, 64'(res_two), 64'd0);
    chk({tag, "_half_one"}, 64'(half_out_one), 64'd0);
    chk({tag, "_half_two"}, 64'(half_out_two), 64'd0);
    chk({tag, "_sq_one"}, 64'(square_out_one), 64'd0);
    chk({tag, "_sq_two"}, 64'(square_out_two), 64'd0);
  endtask

  // enabled-cycle counter shared by model, stub and monitors
  always @(posedge clk) if (!rst && clk_en) ec <= ec + 1;

  // cycles in which a CORDIC done pulse must be ignored by the DUT
  function automatic logic spur_ok();
    return (ec >= free_at) || (ec == acc + 1) || (ec == acc + 2 + lat) ||
           (ec == acc + 3 + 2 * lat);
  endfunction

  // drive one cycle of stimulus and update the reference model
  task automatic step(input logic en, input logic iv, input logic sp,
                      input logic [CW-1:0] a, input logic [CW-1:0] b,
                      input logic [FW-1:0] h1, input logic [FW-1:0] h2,
                      input logic [FW-1:0] s1, input logic [FW-1:0] s2,
                      input int l);
    start_t s;
    res_t   r;
    @(posedge clk); #1;
    clk_en = en; in_valid = iv;
    in_one = a; in_two = b;
    half_in_one = h1; half_in_two = h2; square_in_one = s1; square_in_two = s2;
    if (ec == target) begin
      cordic_done = 1'b1; cordic_result = stub_f(stub_x);
    end else if (sp && spur_ok()) begin
      cordic_done = 1'b1; cordic_result = $urandom;
    end else begin
      cordic_done = 1'b0; cordic_result = $urandom;
    end
    if (en && iv) begin
      if (ec >= free_at) begin
        acc = ec; lat = l; free_at = ec + 4 + 2 * l;
        s.cyc = ec + 1;     s.x = a; start_q.push_back(s);
        s.cyc = ec + 2 + l; s.x = b; start_q.push_back(s);
        r.cyc = ec + 3 + 2 * l;
        r.r1 = stub_f(a); r.r2 = stub_f(b);
        r.h1 = h1; r.h2 = h2; r.s1 = s1; r.s2 = s2;
        res_q.push_back(r);
      end else if (ovr_from > ec + 1) begin
        ovr_from = ec + 1;
      end
    end
  endtask

  task automatic rand_step(input logic en, input logic iv, input logic sp);
    step(en, iv, sp, CW'($urandom), CW'($urandom), $urandom, $urandom,
         $urandom, $urandom, int'($urandom_range(1, 5)));
  endtask

  // asynchronous reset in the middle of an operation
  task automatic do_reset();
    in_valid = 1'b0; cordic_done = 1'b0; clk_en = 1'b1;
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    @(posedge clk); @(posedge clk); @(negedge clk);
    #2 rst = 1'b0;
    start_q.delete(); res_q.delete();
    target = -1; acc = -100; free_at = ec; ovr_from = 32'h3fff_ffff;
  endtask

  // monitor: status flags every cycle, scoreboard pops on start/done
  always @(negedge clk) begin : mon
    start_t s;
    res_t   r;
    if (!rst) begin
      chk("busy", 64'((ec >= acc + 1) && (ec < free_at)), 64'(busy));
      chk("overrun", 64'(overrun), 64'(ec >= ovr_from));
      if (cordic_start) begin
        chk("start_en", 64'(clk_en), 64'd1);
        if (start_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL start_unexpected actual=1 required=0 cyc=%0d", ec);
        end else begin
          s = start_q.pop_front();
          chk("start_cycle", 64'(ec), 64'(s.cyc));
          chk("start_x", 64'(cordic_x), 64'(s.x));
        end
        stub_x = cordic_x;
        target = ec + lat;
      end
      if (done) begin
        chk("done_en", 64'(clk_en), 64'd1);
        if (res_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected actual=1 required=0 cyc=%0d", ec);
        end else begin
          r = res_q.pop_front();
          chk("done_cycle", 64'(ec), 64'(r.cyc));
          chk("res_one", 64'(res_one), 64'(r.r1));
          chk("res_two", 64'(res_two), 64'(r.r2));
          chk("half_one", 64'(half_out_one), 64'(r.h1));
          chk("half_two", 64'(half_out_two), 64'(r.h2));
          chk("sq_one", 64'(square_out_one), 64'(r.s1));
          chk("sq_two", 64'(square_out_two), 64'(r.s2));
        end
      end
    end
  end

  initial begin
    int st1, st2, rel;
    logic rst_done;
    logic iv, en;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk); #2 rst = 1'b0;

    // spurious done in IDLE, then the directed pair with L=3
    step(1'b1, 1'b0, 1'b1, '0, '0, '0, '0, '0, '0, 3);
    step(1'b1, 1'b1, 1'b0, 22'h001000, 22'h002000, 32'h3F000000, 32'h3E800000,
         32'h3E800000, 32'h3D800000, 3);
    // spurious done in ISSUE_ONE, overrun at rel 3 carrying 3FFFFF,
    // back-to-back acceptance at rel 10
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, (k == 3) || (k == 10), k == 1,
           (k == 3) ? 22'h3FFFFF : 22'h0ABCDE, 22'h012345,
           32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 3);
    end

    // clk_en stalls in WAIT_ONE and DONE
    st1 = 0; st2 = 0;
    rand_step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      rel = ec - acc;
      en = 1'b1;
      if (rel == 2 && st1 < 4) begin en = 1'b0; st1++; end
      if (rel == 3 + 2 * lat && st2 < 4) begin en = 1'b0; st2++; end
      rand_step(en, 1'b0, 1'b0);
    end

    // randomized traffic with one reset during WAIT_TWO
    rst_done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      iv = (ec >= free_at) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      rand_step(en, iv, $urandom_range(0, 3) == 0);
      if (!rst_done && i > 200 && ec >= acc + 3 + lat && ec <= acc + 2 + 2 * lat) begin
        do_reset();
        rst_done = 1'b1;
      end
    end
    chk("reset_exercised", 64'(rst_done), 64'd1);

    // drain with a bounded cycle budget
    for (int i = 0; i < 500; i++) begin
      if (ec > free_at && start_q.size() == 0 && res_q.size() == 0) break;
      rand_step($urandom_range(0, 3) != 0, 1'b0, 1'b0);
    end
    chk("start_q_drained", 64'(start_q.size()), 64'd0);
    chk("res_q_drained", 64'(res_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
